multi_trg_stretch: RTL and testbench

MULTI_TRG_STRETCH -- requirements
Module: multi_trg_stretch

---
 rtl/multi_trg_stretch_pkg.sv | 16 +
 rtl/multi_trg_stretch_chan.sv | 94 +++++++++
 rtl/multi_trg_stretch.sv | 61 ++++++
 tb/tb_multi_trg_stretch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_trg_stretch_pkg.sv
// Shared definitions for the multi-channel trigger stretcher: channel FSM
// state encoding, default geometry and the coincidence threshold width.
package multi_trg_stretch_pkg;

    localparam int DEF_NCH     = 4;
    localparam int DEF_CW      = 8;
    localparam int COINC_THR_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_DELAY   = 4'b0010,
        ST_PULSE   = 4'b0100,
        ST_WAITLOW = 4'b1000
    } chanState_t;

endpackage

// File: rtl/multi_trg_stretch_chan.sv
// Single trigger channel: accepts a level request, waits the latched delay,
// emits a pulse of the latched length, then waits for the request to drop.
module trg_stretch_chan
    import multi_trg_stretch_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          TReqIn,
    input  logic          ChanEn,
    input  logic [CW-1:0] TrgDly,
    input  logic [CW-1:0] TrgLen,
    output logic          TrgPls,
    output logic          Busy
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    chanState_t    state;
    chanState_t    nextState;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dlyLat;
    logic [CW-1:0] lenLat;
    logic [CW-1:0] lenLast;
    logic          accept;
    logic          lastDelay;
    logic          lastPulse;

    // A zero length behaves as a one-clock pulse, so the terminal count is
    // clamped at zero rather than wrapping to all ones.
    assign lenLast   = (lenLat == '0) ? '0 : (lenLat - ONE);
    assign accept    = TReqIn & ChanEn;
    assign lastDelay = (cnt == (dlyLat - ONE));
    assign lastPulse = (cnt == lenLast);

    // State register plus the counter and the per-trigger latched fields.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dlyLat <= '0;
            lenLat <= '0;
        end else begin
            state <= nextState;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        dlyLat <= TrgDly;
                        lenLat <= TrgLen;
                    end
                end
                ST_DELAY: cnt <= lastDelay ? '0 : (cnt + ONE);
                ST_PULSE: cnt <= lastPulse ? '0 : (cnt + ONE);
                default:  cnt <= '0;
            endcase
        end
    end

    // Next-state logic; request activity is only looked at in IDLE and WAITLOW.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState = (TrgDly == '0) ? ST_PULSE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (lastDelay) begin
                    nextState = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (lastPulse) begin
                    nextState = ST_WAITLOW;
                end
            end
            ST_WAITLOW: begin
                if (!TReqIn) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        TrgPls = (state == ST_PULSE);
        Busy   = (state != ST_IDLE);
    end

endmodule

// File: rtl/multi_trg_stretch.sv
// Multi-channel fast-OR trigger stretcher with optional registered coincidence
// output; define TRG_COINC_EN to build the coincidence counter.
module multi_trg_stretch
    import multi_trg_stretch_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NCH-1:0]         TReqIn,
    input  logic [NCH-1:0]         ChanEn,
    input  logic [NCH*CW-1:0]      TrgDly,
    input  logic [NCH*CW-1:0]      TrgLen,
    input  logic [COINC_THR_W-1:0] CoincThr,
    output logic [NCH-1:0]         TrgPls,
    output logic                   TrgCoinc,
    output logic [NCH-1:0]         Busy
);

    for (genvar i = 0; i < NCH; i++) begin : genChan
        trg_stretch_chan #(
            .CW(CW)
        ) uChan (
            .Clock (Clock),
            .Reset (Reset),
            .TReqIn(TReqIn[i]),
            .ChanEn(ChanEn[i]),
            .TrgDly(TrgDly[i*CW +: CW]),
            .TrgLen(TrgLen[i*CW +: CW]),
            .TrgPls(TrgPls[i]),
            .Busy  (Busy[i])
        );
    end

`ifdef TRG_COINC_EN
    logic [COINC_THR_W-1:0] pulseCount;

    always_comb begin
        pulseCount = '0;
        for (int i = 0; i < NCH; i++) begin
            pulseCount = pulseCount + {{(COINC_THR_W-1){1'b0}}, TrgPls[i]};
        end
    end

    // A zero threshold disables the flag instead of asserting it permanently.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            TrgCoinc <= 1'b0;
        end else begin
            TrgCoinc <= (CoincThr != '0) && (pulseCount >= CoincThr);
        end
    end
`else
    logic unusedCoincThr;

    assign unusedCoincThr = ^CoincThr;
    assign TrgCoinc       = 1'b0;
`endif

endmodule

// File: tb/tb_multi_trg_stretch.sv
// Testbench for multi_trg_stretch: directed scenarios plus randomized traffic
// against a timestamp-based reference model of each channel.
module tb_multi_trg_stretch;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [NCH-1:0]    TReqIn = '0;
    logic [NCH-1:0]    ChanEn = '0;
    logic [NCH*CW-1:0] TrgDly = '0;
    logic [NCH*CW-1:0] TrgLen = '0;
    logic [4:0]        CoincThr = '0;
    logic [NCH-1:0]    TrgPls;
    logic              TrgCoinc;
    logic [NCH-1:0]    Busy;

    multi_trg_stretch #(
        .NCH(NCH),
        .CW (CW)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .TReqIn  (TReqIn),
        .ChanEn  (ChanEn),
        .TrgDly  (TrgDly),
        .TrgLen  (TrgLen),
        .CoincThr(CoincThr),
        .TrgPls  (TrgPls),
        .TrgCoinc(TrgCoinc),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: each active channel is described by the edge indices
    // at which its pulse starts and ends.
    int             cycleNo = 0;
    bit             active [NCH];
    int             startC [NCH];
    int             endC   [NCH];
    logic [NCH-1:0] expPls   = '0;
    logic [NCH-1:0] expBusy  = '0;
    logic           expCoinc = 1'b0;

    int             highCnt [NCH];
    int             riseCnt [NCH];
    int             coincCnt = 0;
    logic [NCH-1:0] prevObs  = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycleNo, observed, expected);
        end
    endtask

    function automatic int countOnes(input logic [NCH-1:0] v);
        int n = 0;
        for (int i = 0; i < NCH; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) active[c] = 1'b0;
        expPls   = '0;
        expBusy  = '0;
        expCoinc = 1'b0;
    endtask

    task automatic modelStep();
        logic [NCH-1:0] newPls;
        int d;
        int l;
        newPls = '0;
        for (int c = 0; c < NCH; c++) begin
            if (active[c]) begin
                if (cycleNo >= endC[c] + 2 && !TReqIn[c]) active[c] = 1'b0;
            end else if (TReqIn[c] && ChanEn[c]) begin
                d = int'(TrgDly[c*CW +: CW]);
                l = int'(TrgLen[c*CW +: CW]);
                if (l == 0) l = 1;
                active[c] = 1'b1;
                startC[c] = cycleNo + d;
                endC[c]   = startC[c] + l - 1;
            end
            newPls[c]  = active[c] && (cycleNo >= startC[c]) && (cycleNo <= endC[c]);
            expBusy[c] = active[c];
        end
`ifdef TRG_COINC_EN
        expCoinc = (CoincThr != 0) && (countOnes(expPls) >= int'(CoincThr));
`else
        expCoinc = 1'b0;
`endif
        expPls = newPls;
    endtask

    task automatic clearStats();
        for (int c = 0; c < NCH; c++) begin
            highCnt[c] = 0;
            riseCnt[c] = 0;
        end
        coincCnt = 0;
    endtask

    // Runs n clock edges with the current inputs, checking every cycle.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            cycleNo++;
            if (!Reset) modelReset();
            else modelStep();
            #1;
            checkOutput("TrgPls", 32'(TrgPls), 32'(expPls));
            checkOutput("Busy", 32'(Busy), 32'(expBusy));
            checkOutput("TrgCoinc", 32'(TrgCoinc), 32'(expCoinc));
            for (int c = 0; c < NCH; c++) begin
                highCnt[c] += int'(TrgPls[c]);
                if (TrgPls[c] && !prevObs[c]) riseCnt[c]++;
            end
            coincCnt += int'(TrgCoinc);
            prevObs = TrgPls;
        end
    endtask

    task automatic setChan(input int ch, input int dly, input int len);
        TrgDly[ch*CW +: CW] = CW'(dly);
        TrgLen[ch*CW +: CW] = CW'(len);
    endtask

    task automatic assertReset();
        Reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rstPls", 32'(TrgPls), 32'd0);
        checkOutput("rstBusy", 32'(Busy), 32'd0);
        checkOutput("rstCoinc", 32'(TrgCoinc), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        modelReset();
        clearStats();
        applyStimulus(2);
        checkOutput("initPls", 32'(TrgPls), 32'd0);
        checkOutput("initBusy", 32'(Busy), 32'd0);
        Reset  = 1'b1;
        ChanEn = '1;
        applyStimulus(2);

        // Level held high for ten clocks gives a single three-clock pulse.
        clearStats();
        setChan(0, 0, 3);
        TReqIn[0] = 1'b1;
        applyStimulus(10);
        TReqIn[0] = 1'b0;
        applyStimulus(5);
        checkOutput("ch0Width", 32'(highCnt[0]), 32'd3);
        checkOutput("ch0Pulses", 32'(riseCnt[0]), 32'd1);

        // Delay five, length two, with a retrigger attempt three edges later.
        clearStats();
        setChan(1, 5, 2);
        TReqIn[1] = 1'b1;
        applyStimulus(1);
        TReqIn[1] = 1'b0;
        applyStimulus(2);
        TReqIn[1] = 1'b1;
        applyStimulus(1);
        TReqIn[1] = 1'b0;
        applyStimulus(10);
        checkOutput("ch1Width", 32'(highCnt[1]), 32'd2);
        checkOutput("ch1Pulses", 32'(riseCnt[1]), 32'd1);

        // Length extremes, and a length change while the pulse is running.
        clearStats();
        setChan(2, 0, 0);
        TReqIn[2] = 1'b1;
        applyStimulus(1);
        TReqIn[2] = 1'b0;
        applyStimulus(4);
        checkOutput("ch2Len0", 32'(highCnt[2]), 32'd1);
        clearStats();
        setChan(2, 0, 255);
        TReqIn[2] = 1'b1;
        applyStimulus(1);
        TReqIn[2] = 1'b0;
        applyStimulus(2);
        setChan(2, 0, 4);
        applyStimulus(270);
        checkOutput("ch2Len255", 32'(highCnt[2]), 32'd255);

        // Channels 0 and 3 overlap for four clocks.
        clearStats();
        CoincThr = 5'd2;
        setChan(0, 0, 6);
        setChan(3, 2, 8);
        TReqIn = 4'b1001;
        applyStimulus(1);
        TReqIn = '0;
        applyStimulus(14);
`ifdef TRG_COINC_EN
        checkOutput("coincLen", 32'(coincCnt), 32'd4);
`else
        checkOutput("coincOff", 32'(coincCnt), 32'd0);
`endif
        clearStats();
        CoincThr = 5'd0;
        TReqIn = 4'b1001;
        applyStimulus(1);
        TReqIn = '0;
        applyStimulus(14);
        checkOutput("coincThr0", 32'(coincCnt), 32'd0);

        // Reset in the middle of a delay and in the middle of a pulse.
        setChan(1, 10, 3);
        TReqIn[1] = 1'b1;
        applyStimulus(3);
        TReqIn[1] = 1'b0;
        assertReset();
        applyStimulus(2);
        Reset = 1'b1;
        applyStimulus(2);
        setChan(0, 0, 20);
        TReqIn[0] = 1'b1;
        applyStimulus(5);
        assertReset();
        applyStimulus(2);
        Reset = 1'b1;
        applyStimulus(1);
        checkOutput("relPls0", 32'(TrgPls[0]), 32'd1);
        TReqIn[0] = 1'b0;
        applyStimulus(25);

        // Disabled channel ignores its input; disabling during DELAY does not abort.
        clearStats();
        ChanEn[2] = 1'b0;
        setChan(2, 0, 2);
        for (int k = 0; k < 10; k++) begin
            TReqIn[2] = ~TReqIn[2];
            applyStimulus(1);
        end
        TReqIn[2] = 1'b0;
        checkOutput("ch2DisPls", 32'(highCnt[2]), 32'd0);
        checkOutput("ch2DisBusy", 32'(Busy[2]), 32'd0);
        ChanEn[2] = 1'b1;
        clearStats();
        setChan(1, 4, 2);
        TReqIn[1] = 1'b1;
        applyStimulus(1);
        TReqIn[1] = 1'b0;
        ChanEn[1] = 1'b0;
        applyStimulus(10);
        checkOutput("ch1EnDrop", 32'(highCnt[1]), 32'd2);
        ChanEn[1] = 1'b1;

        // Randomized traffic with live configuration changes.
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) TReqIn[c] = ~TReqIn[c];
                if ($urandom_range(0, 7) == 0) ChanEn[c] = ~ChanEn[c];
                else if ($urandom_range(0, 7) == 0) ChanEn[c] = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    setChan(c,
                            ($urandom_range(0, 63) == 0) ? 255 : int'($urandom_range(0, 12)),
                            ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 8)));
                end
            end
            if ($urandom_range(0, 19) == 0) CoincThr = 5'($urandom_range(0, 5));
            if ($urandom_range(0, 499) == 0) begin
                assertReset();
                applyStimulus(2);
                Reset = 1'b1;
            end
            applyStimulus(1);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
